// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the MEM-stage data
// requester: one transaction in flight, data first, with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    input  logic        data_en,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wmask,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_rdata_valid,
    output logic        data_write_finish,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wmask,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic {OWN_INST, OWN_DATA} owner_e;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic starved, grant_data, grant_inst, capture, deliver;

    // Fetch wins over a pending data request once data has had its run.
    assign starved    = inst_en && (cnt_q >= LIMIT);
    assign grant_data = (state_q == IDLE) && !flush && data_en && !starved;
    assign grant_inst = (state_q == IDLE) && !flush && inst_en && !grant_data;
    assign capture    = ((state_q == ISSUE) && bus_addr_ok && bus_data_ok) ||
                        ((state_q == WAIT) && bus_data_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            discard_q    <= 1'b0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_data || grant_inst) state_d = ISSUE;
            ISSUE:   if (bus_addr_ok) state_d = bus_data_ok ? RESP : WAIT;
            WAIT:    if (bus_data_ok) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        discard_d    = discard_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        if (grant_data) begin
            owner_d = OWN_DATA;
            we_d    = data_we;
            addr_d  = data_addr;
            wmask_d = data_wmask;
            wdata_d = data_wdata;
            if (!inst_en)
                cnt_d = '0;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end else if (grant_inst) begin
            owner_d = OWN_INST;
            we_d    = 1'b0;
            addr_d  = inst_addr;
            wmask_d = 4'b1111;
            wdata_d = '0;
            cnt_d   = '0;
        end

        // A flushed transaction still runs to completion on the bus; only its reply is dropped.
        if (flush && (state_q == ISSUE || state_q == WAIT))
            discard_d = 1'b1;
        else if (state_q == RESP)
            discard_d = 1'b0;

        if (capture) begin
            if (owner_q == OWN_INST)
                inst_rdata_d = bus_rdata;
            else if (!we_q)
                data_rdata_d = bus_rdata;
        end
    end

    always_comb begin
        deliver           = (state_q == RESP) && !discard_q && !flush;
        bus_req           = (state_q == ISSUE);
        busy              = (state_q != IDLE);
        inst_rdata_valid  = deliver && (owner_q == OWN_INST);
        data_rdata_valid  = deliver && (owner_q == OWN_DATA) && !we_q;
        data_write_finish = deliver && (owner_q == OWN_DATA) && we_q;
    end

    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wmask  = wmask_q;
    assign bus_wdata  = wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of
// the fetch/data arbitration, starvation guard and completion pulses.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset, flush, inst_en, data_en, data_we, bus_addr_ok, bus_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [3:0]  data_wmask;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        inst_rdata_valid, data_rdata_valid, data_write_finish;
    logic        bus_req, bus_we, busy;
    logic [3:0]  bus_wmask;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_rdata_valid(inst_rdata_valid),
        .data_en(data_en), .data_we(data_we), .data_addr(data_addr),
        .data_wmask(data_wmask), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_rdata_valid(data_rdata_valid), .data_write_finish(data_write_finish),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wmask(bus_wmask),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus_req === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; inst_en = 1'b0; data_en = 1'b0; data_we = 1'b0;
        inst_addr = '0; data_addr = '0; data_wmask = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus_req, busy, inst_rdata_valid, data_rdata_valid, data_write_finish, bus_we, bus_wmask} !== 10'b0)
            $display("FAIL reset_ctrl: got %b want 0", {bus_req, busy, inst_rdata_valid, data_rdata_valid, data_write_finish, bus_we, bus_wmask});
        else n_pass++;
        n_chk++;
        if ({bus_addr, bus_wdata, inst_rdata, data_rdata} !== 128'b0)
            $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, inst_rdata, data_rdata});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        inst_en = 1'b1; inst_addr = 32'h1c000000;
        @(negedge clk);
        n_chk++;
        if ({bus_req, bus_we, bus_wmask, bus_addr} !== {1'b1, 1'b0, 4'hf, 32'h1c000000})
            $display("FAIL fetch_issue: got %h want %h", {bus_req, bus_we, bus_wmask, bus_addr}, {1'b1, 1'b0, 4'hf, 32'h1c000000});
        else n_pass++;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        n_chk++;
        if ({bus_req, busy, inst_rdata_valid} !== 3'b010)
            $display("FAIL fetch_wait: got %b want 010", {bus_req, busy, inst_rdata_valid});
        else n_pass++;
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h02800413;
        @(negedge clk);
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        n_chk++;
        if ({inst_rdata_valid, data_rdata_valid, data_write_finish, bus_req, inst_rdata} !== {4'b1000, 32'h02800413})
            $display("FAIL fetch_pulse: got %h want %h", {inst_rdata_valid, data_rdata_valid, data_write_finish, bus_req, inst_rdata}, {4'b1000, 32'h02800413});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus_req, busy, inst_rdata_valid, inst_rdata} !== {3'b000, 32'h02800413})
            $display("FAIL fetch_no_regrant: got %h want %h", {bus_req, busy, inst_rdata_valid, inst_rdata}, {3'b000, 32'h02800413});
        else n_pass++;
        inst_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        inst_en = 1'b1; inst_addr = 32'h1c000004;
        data_en = 1'b1; data_we = 1'b1; data_addr = 32'h1000; data_wmask = 4'b0100; data_wdata = 32'h00AB0000;
        @(negedge clk);
        n_chk++;
        if ({bus_req, bus_we, bus_wmask, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0100, 32'h1000, 32'h00AB0000})
            $display("FAIL simul_store_first: got %h want %h", {bus_req, bus_we, bus_wmask, bus_addr, bus_wdata}, {1'b1, 1'b1, 4'b0100, 32'h1000, 32'h00AB0000});
        else n_pass++;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        @(negedge clk);
        bus_data_ok = 1'b0;
        n_chk++;
        if ({data_write_finish, data_rdata_valid, inst_rdata_valid} !== 3'b100)
            $display("FAIL simul_store_finish: got %b want 100", {data_write_finish, data_rdata_valid, inst_rdata_valid});
        else n_pass++;
        data_en = 1'b0; data_we = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus_req, bus_we, bus_wmask, bus_addr} !== {1'b1, 1'b0, 4'hf, 32'h1c000004})
            $display("FAIL simul_fetch_second: got %h want %h", {bus_req, bus_we, bus_wmask, bus_addr}, {1'b1, 1'b0, 4'hf, 32'h1c000004});
        else n_pass++;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h00000013;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        n_chk++;
        if ({inst_rdata_valid, inst_rdata} !== {1'b1, 32'h00000013})
            $display("FAIL simul_fetch_done: got %h want %h", {inst_rdata_valid, inst_rdata}, {1'b1, 32'h00000013});
        else n_pass++;
        inst_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        bit ok, exp_inst;
        logic [31:0] exp_addr;
        data_en = 1'b1; data_we = 1'b0; data_addr = 32'h2000;
        inst_en = 1'b1; inst_addr = 32'h1c000100;
        for (int t = 0; t < 10; t++) begin
            exp_inst = (t % 5 == 4);
            exp_addr = exp_inst ? inst_addr : data_addr;
            wait_req(ok);
            n_chk++;
            if (!ok || bus_addr !== exp_addr)
                $display("FAIL starve_order[%0d]: got req=%b addr=%h want addr=%h", t, ok, bus_addr, exp_addr);
            else n_pass++;
            bus_addr_ok = 1'b1;
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h100 + t;
            @(negedge clk);
            bus_data_ok = 1'b0;
            n_chk++;
            if ({inst_rdata_valid, data_rdata_valid} !== (exp_inst ? 2'b10 : 2'b01))
                $display("FAIL starve_pulse[%0d]: got %b want %b", t, {inst_rdata_valid, data_rdata_valid}, (exp_inst ? 2'b10 : 2'b01));
            else n_pass++;
            if (exp_inst) inst_addr = inst_addr + 32'd4;
            else data_addr = data_addr + 32'd4;
        end
        data_en = 1'b0; inst_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        bit ok;
        data_en = 1'b1; data_we = 1'b0; data_addr = 32'h3000; flush = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus_req, busy} !== 2'b00)
            $display("FAIL flush_blocks_grant: got %b want 00", {bus_req, busy});
        else n_pass++;
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h3000})
            $display("FAIL flush_then_grant: got %h want %h", {bus_req, bus_addr}, {1'b1, 32'h3000});
        else n_pass++;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; data_en = 1'b0;
        n_chk++;
        if ({bus_req, busy} !== 2'b01)
            $display("FAIL flush_wait: got %b want 01", {bus_req, busy});
        else n_pass++;
        bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_data_ok = 1'b0;
        n_chk++;
        if ({data_rdata_valid, inst_rdata_valid, data_write_finish, busy} !== 4'b0001)
            $display("FAIL flush_discard: got %b want 0001", {data_rdata_valid, inst_rdata_valid, data_write_finish, busy});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({busy, bus_req} !== 2'b00)
            $display("FAIL flush_idle: got %b want 00", {busy, bus_req});
        else n_pass++;
        // flush landing in the response cycle itself
        data_en = 1'b1; data_addr = 32'h3004;
        wait_req(ok);
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; data_en = 1'b0;
        flush = 1'b1;
        #1;
        n_chk++;
        if ({ok, data_rdata_valid, busy} !== 3'b101)
            $display("FAIL flush_in_resp: got %b want 101", {ok, data_rdata_valid, busy});
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        data_en = 1'b1; data_addr = 32'h3008;
        wait_req(ok);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A1234;
        @(negedge clk);
        bus_data_ok = 1'b0;
        n_chk++;
        if ({ok, data_rdata_valid, data_rdata} !== {2'b11, 32'h5A5A1234})
            $display("FAIL flush_recover: got %h want %h", {ok, data_rdata_valid, data_rdata}, {2'b11, 32'h5A5A1234});
        else n_pass++;
        data_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_latency();
        inst_en = 1'b1; inst_addr = 32'h1c000200;
        @(negedge clk);
        n_chk++;
        if (bus_req !== 1'b1) $display("FAIL zl_req: got %b want 1", bus_req);
        else n_pass++;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        n_chk++;
        if ({inst_rdata_valid, bus_req, busy, inst_rdata} !== {3'b101, 32'h12345678})
            $display("FAIL zl_pulse: got %h want %h", {inst_rdata_valid, bus_req, busy, inst_rdata}, {3'b101, 32'h12345678});
        else n_pass++;
        inst_en = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, inst_rdata_valid} !== 2'b00) $display("FAIL zl_idle: got %b want 00", {busy, inst_rdata_valid});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        inst_en = 1'b1; inst_addr = 32'h1c000300;
        @(negedge clk);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        n_chk++;
        if ({busy, bus_req} !== 2'b10) $display("FAIL ar_wait: got %b want 10", {busy, bus_req});
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({busy, bus_req, inst_rdata_valid, data_rdata_valid, data_write_finish, bus_addr} !== {5'b0, 32'h0})
            $display("FAIL ar_immediate: got %h want 0", {busy, bus_req, inst_rdata_valid, data_rdata_valid, data_write_finish, bus_addr});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus_req, bus_addr, bus_wmask} !== {1'b1, 32'h1c000300, 4'hf})
            $display("FAIL ar_rearb: got %h want %h", {bus_req, bus_addr, bus_wmask}, {1'b1, 32'h1c000300, 4'hf});
        else n_pass++;
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus_data_ok = 1'b0;
        n_chk++;
        if ({inst_rdata_valid, inst_rdata} !== {1'b1, 32'h0BADF00D})
            $display("FAIL ar_complete: got %h want %h", {inst_rdata_valid, inst_rdata}, {1'b1, 32'h0BADF00D});
        else n_pass++;
        inst_en = 1'b0;
        @(negedge clk);
    endtask

    // Model: phase of the single outstanding transaction, winner picked from the
    // requests visible at the arbitration edge with a plain integer starvation count.
    task automatic test_random();
        int ph, prev_ph, starve, txns;
        bit gexp, aok, dok, own_data;
        logic [31:0] rd, exp_addr, exp_wdata;
        logic [3:0] exp_mask;
        logic exp_we;
        logic [2:0] exp_p;
        ph = 0; starve = 0; txns = 0; gexp = 0; aok = 0; dok = 0; own_data = 0;
        rd = '0; exp_addr = '0; exp_wdata = '0; exp_mask = '0; exp_we = 1'b0;
        reset = 1'b1; inst_en = 1'b0; data_en = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            prev_ph = ph;
            case (ph)
                0: ph = gexp ? 1 : 0;
                1: ph = aok ? (dok ? 3 : 2) : 1;
                2: ph = dok ? 3 : 2;
                default: ph = 0;
            endcase
            if (ph == 1 && prev_ph == 0) begin
                txns++;
                if (data_en && !(inst_en && starve >= 4)) begin
                    own_data = 1'b1;
                    starve = inst_en ? ((starve < 7) ? starve + 1 : 7) : 0;
                    exp_we = data_we; exp_addr = data_addr; exp_mask = data_wmask; exp_wdata = data_wdata;
                end else begin
                    own_data = 1'b0; starve = 0;
                    exp_we = 1'b0; exp_addr = inst_addr; exp_mask = 4'hf; exp_wdata = '0;
                end
            end
            n_chk++;
            if ({busy, bus_req} !== {ph != 0, ph == 1})
                $display("FAIL rnd_phase[%0d]: got %b want %b", c, {busy, bus_req}, {ph != 0, ph == 1});
            else n_pass++;
            if (ph == 1) begin
                n_chk++;
                if ({bus_we, bus_addr, bus_wmask} !== {exp_we, exp_addr, exp_mask} || (exp_we && bus_wdata !== exp_wdata))
                    $display("FAIL rnd_issue[%0d]: got %h/%h want %h/%h", c, {bus_we, bus_addr, bus_wmask}, bus_wdata, {exp_we, exp_addr, exp_mask}, exp_wdata);
                else n_pass++;
            end
            exp_p = (ph == 3) ? {!own_data, own_data && !exp_we, own_data && exp_we} : 3'b000;
            n_chk++;
            if ({inst_rdata_valid, data_rdata_valid, data_write_finish} !== exp_p)
                $display("FAIL rnd_pulse[%0d]: got %b want %b", c, {inst_rdata_valid, data_rdata_valid, data_write_finish}, exp_p);
            else n_pass++;
            if (ph == 3 && !(own_data && exp_we)) begin
                n_chk++;
                if ((own_data ? data_rdata : inst_rdata) !== rd)
                    $display("FAIL rnd_rdata[%0d]: got %h want %h", c, (own_data ? data_rdata : inst_rdata), rd);
                else n_pass++;
            end
            // requesters: the finished owner may reissue at once, others raise at random
            if (ph == 3 && own_data) data_en = 1'b0;
            if (ph == 3 && !own_data) inst_en = 1'b0;
            if (!inst_en && $urandom_range(0, 2) == 0) begin
                inst_en = 1'b1; inst_addr = 32'h1c000000 | ($urandom & 32'h0000fffc);
            end
            if (!data_en && $urandom_range(0, 1) == 0) begin
                data_en = 1'b1; data_we = 1'($urandom_range(0, 1));
                data_addr = $urandom & 32'h0000fffc; data_wmask = 4'($urandom); data_wdata = $urandom;
            end
            // slave
            aok = 1'b0; dok = 1'b0;
            if (ph == 1 && $urandom_range(0, 1) == 1) begin
                aok = 1'b1; dok = ($urandom_range(0, 3) == 0);
            end else if (ph == 2) begin
                dok = ($urandom_range(0, 2) == 0);
            end
            if (dok) rd = $urandom;
            bus_addr_ok = aok; bus_data_ok = dok;
            bus_rdata = dok ? rd : $urandom;
            gexp = (ph == 0) && (inst_en || data_en);
        end
        n_chk++;
        if (txns < 100) $display("FAIL rnd_progress: got %0d transactions want >= 100", txns);
        else n_pass++;
        inst_en = 1'b0; data_en = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_zero_latency();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
